// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding controller.
//   state_t       - memory-wait FSM state (RUN, MEM_WAIT)
//   FWD_SEL_RF    - forward select value meaning "take the register file"
//   fwd_sel_w()   - width of one forward select for a given stage count
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int FWD_SEL_RF = 0;

    // Select encodes 0 (register file) plus one code per forwarding stage.
    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: bundle between the pipeline and the hazard unit.
//   Pipeline -> unit: source/destination addresses, write/load flags, mem_ready.
//   Unit -> pipeline: forward selects, stall/bubble/freeze, error and counters,
//   plus the FSM state for observation.
// Modports: master = pipeline side, slave = hazard_forward_ctrl.
//
// Handshake: there is no valid/ready pair here. The only flow-control signal is
// mem_ready, which qualifies a load sitting in EX/MEM (stage0_is_load). While
// stage0_is_load=1 and mem_ready=0 the pipeline must hold every register
// (freeze); the cycle mem_ready=1 is seen, the load data is taken and the
// pipeline advances on that edge.
interface hazard_forward_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = fwd_sel_w(FWD_STAGES);

    logic [NUM_SRC*REG_AW-1:0]    ex_src_flat;
    logic [NUM_SRC*REG_AW-1:0]    id_src_flat;
    logic                         id_valid;
    logic [REG_AW-1:0]            ex_rd;
    logic                         ex_regwrite;
    logic                         ex_is_load;
    logic [FWD_STAGES*REG_AW-1:0] stage_rd_flat;
    logic [FWD_STAGES-1:0]        stage_regwrite;
    logic                         stage0_is_load;
    logic                         mem_ready;

    logic [NUM_SRC*SEL_W-1:0]     forward_sel_flat;
    logic                         stall;
    logic                         bubble;
    logic                         freeze;
    logic                         err_timeout;
    logic [CNT_W-1:0]             stall_cycles;
    logic [CNT_W-1:0]             load_use_events;
    state_t                       state;

    modport master (
        output ex_src_flat, id_src_flat, id_valid, ex_rd, ex_regwrite, ex_is_load,
               stage_rd_flat, stage_regwrite, stage0_is_load, mem_ready,
        input  forward_sel_flat, stall, bubble, freeze, err_timeout,
               stall_cycles, load_use_events, state
    );

    modport slave (
        input  ex_src_flat, id_src_flat, id_valid, ex_rd, ex_regwrite, ex_is_load,
               stage_rd_flat, stage_regwrite, stage0_is_load, mem_ready,
        output forward_sel_flat, stall, bubble, freeze, err_timeout,
               stall_cycles, load_use_events, state
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// fwd_match: compares one EX source address against every forwarding stage and
// returns a priority-encoded select (0 = register file, k+1 = stage k).
//   src            in  source register address
//   stage_rd_flat  in  destination per stage, stage k at [k*REG_AW +: REG_AW]
//   stage_regwrite in  write flag per stage
//   sel            out forward select, youngest (lowest k) matching stage wins
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = fwd_sel_w(FWD_STAGES)
) (
    input  logic [REG_AW-1:0]            src,
    input  logic [FWD_STAGES*REG_AW-1:0] stage_rd_flat,
    input  logic [FWD_STAGES-1:0]        stage_regwrite,
    output logic [SEL_W-1:0]             sel
);

    logic [REG_AW-1:0] rd_k;

    // Walk from the oldest stage to the youngest so the last assignment is the
    // youngest match. A stage writing r0 never matches, so src==0 always
    // resolves to the register file.
    always_comb begin
        sel  = SEL_W'(FWD_SEL_RF);
        rd_k = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            rd_k = stage_rd_flat[k*REG_AW +: REG_AW];
            if (stage_regwrite[k] && (rd_k != '0) && (rd_k == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding selection, load-use stall/bubble
// generation, memory-wait freeze FSM with timeout, and saturating counters.
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of hazard_forward_ctrl_if (all pipeline-facing signals)
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = fwd_sel_w(FWD_STAGES),
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [WC_W-1:0]          wait_cnt;
    logic                     err_q;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic [CNT_W-1:0]         lu_cnt_q;

    logic [NUM_SRC*SEL_W-1:0] sel_raw;
    logic                     src_hit;
    logic                     load_use_hit;
    logic                     freeze_raw;
    logic                     stall_o;
    logic                     bubble_o;
    logic                     freeze_o;

    // ---------------- forwarding ----------------
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .REG_AW    (REG_AW),
            .FWD_STAGES(FWD_STAGES),
            .SEL_W     (SEL_W)
        ) u_match (
            .src           (bus.ex_src_flat[s*REG_AW +: REG_AW]),
            .stage_rd_flat (bus.stage_rd_flat),
            .stage_regwrite(bus.stage_regwrite),
            .sel           (sel_raw[s*SEL_W +: SEL_W])
        );
    end

    assign bus.forward_sel_flat = rst ? '0 : sel_raw;

    // ---------------- hazard detection ----------------
    always_comb begin
        src_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.id_src_flat[s*REG_AW +: REG_AW] == bus.ex_rd) begin
                src_hit = 1'b1;
            end
        end
    end

    assign load_use_hit = bus.id_valid & bus.ex_regwrite & bus.ex_is_load &
                          (bus.ex_rd != '0) & src_hit;

    // Freeze is driven straight from the inputs in either state so the
    // pipeline holds in the very cycle the load is found waiting.
    assign freeze_raw = bus.stage0_is_load & ~bus.mem_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (freeze_raw)  state_d = MEM_WAIT;
            MEM_WAIT: if (!freeze_raw) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Freeze dominates a load-use hit: the bubble is withheld while frozen and
    // the hit is re-evaluated in the cycle mem_ready arrives.
    always_comb begin
        freeze_o = 1'b0;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        if (!rst) begin
            freeze_o = freeze_raw;
            stall_o  = load_use_hit & ~freeze_raw;
            bubble_o = load_use_hit & ~freeze_raw;
        end
    end

    assign bus.freeze = freeze_o;
    assign bus.stall  = stall_o;
    assign bus.bubble = bubble_o;
    assign bus.state  = state_q;

    // ---------------- wait counter and timeout ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (!freeze_raw) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != WC_W'(TIMEOUT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Sticky: the FSM keeps waiting, only reset clears the flag.
            if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_q;

    // ---------------- performance counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            if ((stall_o | freeze_o) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bubble_o && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_cycles    = stall_cnt_q;
    assign bus.load_use_events = lu_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam int EW = 17;  // {sel1,sel0,stall,bubble,freeze,err,state,sc[3:0],lu[3:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(
    .REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .CNT_W(4)
  ) bus ();

  hazard_forward_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .TIMEOUT(4), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] ev(
    input logic [1:0] s0, input logic [1:0] s1,
    input logic stl, input logic bub, input logic frz,
    input logic err, input logic fsm,
    input logic [3:0] sc, input logic [3:0] lu);
    return {s1, s0, stl, bub, frz, err, fsm, sc, lu};
  endfunction

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {bus.forward_sel_flat, bus.stall, bus.bubble, bus.freeze,
           bus.err_timeout, logic'(bus.state), bus.stall_cycles,
           bus.load_use_events};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got sel=%h stl=%b bub=%b frz=%b err=%b st=%b sc=%0d lu=%0d exp sel=%h stl=%b bub=%b frz=%b err=%b st=%b sc=%0d lu=%0d",
                 n, a[16:13], a[12], a[11], a[10], a[9], a[8], a[7:4], a[3:0],
                 e[16:13], e[12], e[11], e[10], e[9], e[8], e[7:4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst                = 1'b0;
    bus.ex_src_flat    = '0;
    bus.id_src_flat    = '0;
    bus.id_valid       = 1'b0;
    bus.ex_rd          = '0;
    bus.ex_regwrite    = 1'b0;
    bus.ex_is_load     = 1'b0;
    bus.stage_rd_flat  = '0;
    bus.stage_regwrite = '0;
    bus.stage0_is_load = 1'b0;
    bus.mem_ready      = 1'b1;
  endtask

  task automatic set_fwd(input logic [4:0] src0, input logic [4:0] src1,
                         input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [1:0] wr);
    bus.ex_src_flat    = {src1, src0};
    bus.stage_rd_flat  = {rd1, rd0};
    bus.stage_regwrite = wr;
  endtask

  task automatic set_lu(input logic valid, input logic [4:0] rd,
                        input logic [4:0] id0, input logic [4:0] id1);
    bus.id_valid    = valid;
    bus.ex_rd       = rd;
    bus.ex_regwrite = 1'b1;
    bus.ex_is_load  = 1'b1;
    bus.id_src_flat = {id1, id0};
  endtask

  task automatic set_mem(input logic is_load, input logic ready);
    bus.stage0_is_load = is_load;
    bus.mem_ready      = ready;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic chk(input string n, input logic [EW-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    checks++;
    if ((bus.state !== RUN) || (bus.err_timeout !== 1'b0) ||
        (bus.stall_cycles !== 4'd0) || (bus.load_use_events !== 4'd0)) begin
      errors++;
      $display("FAIL reset_state st=%b err=%b sc=%0d lu=%0d",
               bus.state, bus.err_timeout, bus.stall_cycles, bus.load_use_events);
    end

    // Reset forces combinational outputs low even with live hazards.
    set_fwd(3, 3, 3, 3, 2'b11);
    set_lu(1, 5, 0, 5);
    set_mem(1, 0);
    chk("rst_force", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Forwarding
    set_idle();
    set_fwd(3, 0, 3, 3, 2'b11); chk("fwd_young",   ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    set_fwd(3, 0, 3, 3, 2'b10); chk("fwd_old",     ev(2, 0, 0, 0, 0, 0, 0, 0, 0));
    set_fwd(0, 0, 0, 3, 2'b11); chk("fwd_zero",    ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_fwd(6, 7, 4, 6, 2'b11); chk("fwd_nomatch", ev(2, 0, 0, 0, 0, 0, 0, 0, 0));
    set_fwd(4, 6, 4, 6, 2'b11); chk("fwd_both",    ev(1, 2, 0, 0, 0, 0, 0, 0, 0));

    // Load-use
    set_idle(); set_lu(1, 5, 0, 5); chk("load_use",   ev(0, 0, 1, 1, 0, 0, 0, 0, 0));
    set_idle();                     chk("lu_done",    ev(0, 0, 0, 0, 0, 0, 0, 1, 1));
    set_lu(0, 5, 0, 5);             chk("lu_novalid", ev(0, 0, 0, 0, 0, 0, 0, 1, 1));
    set_lu(1, 0, 0, 0);             chk("lu_rd0",     ev(0, 0, 0, 0, 0, 0, 0, 1, 1));

    // Short memory wait
    set_idle(); set_mem(1, 0); chk("frz1",      ev(0, 0, 0, 0, 1, 0, 0, 1, 1));
                               chk("frz2",      ev(0, 0, 0, 0, 1, 0, 1, 2, 1));
                               chk("frz3",      ev(0, 0, 0, 0, 1, 0, 1, 3, 1));
    set_mem(1, 1);             chk("frz_end",   ev(0, 0, 0, 0, 0, 0, 1, 4, 1));
    set_idle();                chk("run_again", ev(0, 0, 0, 0, 0, 0, 0, 4, 1));

    // Load-use hit held off by freeze, released with mem_ready
    set_lu(1, 5, 0, 5); set_mem(1, 0); chk("lu_frz1",    ev(0, 0, 0, 0, 1, 0, 0, 4, 1));
                                       chk("lu_frz2",    ev(0, 0, 0, 0, 1, 0, 1, 5, 1));
    set_mem(1, 1);                     chk("lu_release", ev(0, 0, 1, 1, 0, 0, 1, 6, 1));
    set_idle();                        chk("lu_after",   ev(0, 0, 0, 0, 0, 0, 0, 7, 2));

    // Timeout (TIMEOUT=4): error visible after the 4th freeze edge
    set_mem(1, 0); chk("to1", ev(0, 0, 0, 0, 1, 0, 0, 7, 2));
                   chk("to2", ev(0, 0, 0, 0, 1, 0, 1, 8, 2));
                   chk("to3", ev(0, 0, 0, 0, 1, 0, 1, 9, 2));
                   chk("to4", ev(0, 0, 0, 0, 1, 0, 1, 10, 2));
                   chk("to5", ev(0, 0, 0, 0, 1, 1, 1, 11, 2));
                   chk("to6", ev(0, 0, 0, 0, 1, 1, 1, 12, 2));

    checks++;
    if ((bus.err_timeout !== 1'b1) || (bus.state !== MEM_WAIT)) begin
      errors++;
      $display("FAIL expired_wait err=%b st=%b", bus.err_timeout, bus.state);
    end

    set_mem(1, 1); chk("to_release", ev(0, 0, 0, 0, 0, 1, 1, 13, 2));
    set_idle();    chk("err_sticky", ev(0, 0, 0, 0, 0, 1, 0, 13, 2));

    // Counter saturation at 4'hF
    set_mem(1, 0); chk("sat1", ev(0, 0, 0, 0, 1, 1, 0, 13, 2));
                   chk("sat2", ev(0, 0, 0, 0, 1, 1, 1, 14, 2));
                   chk("sat3", ev(0, 0, 0, 0, 1, 1, 1, 15, 2));
                   chk("sat4", ev(0, 0, 0, 0, 1, 1, 1, 15, 2));
                   chk("sat5", ev(0, 0, 0, 0, 1, 1, 1, 15, 2));

    // Reset in the middle of a wait, mem_ready still low
    rst = 1'b1;    chk("rst_mid",  ev(0, 0, 0, 0, 0, 1, 1, 15, 2));
    rst = 1'b0;    chk("rst_done", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    set_mem(1, 1); chk("post_rst", ev(0, 0, 0, 0, 0, 0, 1, 1, 0));

    set_idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
